// File: rtl/uart_tx_fifo_if.sv
// Producer-side write handshake plus status and serial line of uart_tx_fifo.
// master = producer/observer side, slave = the transmitter itself.
// fifo_count is wide enough to hold FIFO_DEPTH (full) as a value.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                        tx_valid;
    logic [DATA_BITS-1:0]        tx_data;
    logic                        tx_ready;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        uart_tx_busy;
    logic                        uart_txd;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  fifo_count,
        input  uart_tx_busy,
        input  uart_txd
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output fifo_count,
        output uart_tx_busy,
        output uart_txd
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frames are sent back to back with no idle gap.
// Latency: word accepted at edge k into an empty FIFO while idle drives the start bit at edge k+1.
// Backpressure: tx_ready = !full; the producer may hold tx_valid high indefinitely.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    uart_tx_fifo_if.slave bus
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW      = AW + 1;
    localparam int BW      = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(BPS_CNT - 1);
    localparam logic [3:0]    DBIT_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    SBIT_LAST = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    // Parameter sanity: refuse to elaborate an unsupported configuration.
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "uart_tx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $fatal(1, "uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $fatal(1, "uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (BPS_CNT < 2) begin : g_bad_baud
        $fatal(1, "uart_tx_fifo: CLK_FREQ/UART_BPS must be >= 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ready, push, pop, fifo_empty;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    state_t               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 baud_end;

    assign ready      = (count_q != FULL_CNT);
    assign push       = bus.tx_valid && ready;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    // Parity is resolved once at load time so the PAR state only replays it.
    assign head_par   = (PARITY == 1) ? ~^head : ^head;
    assign baud_end   = (baud_q == BAUD_LAST);

    assign bus.tx_ready     = ready;
    assign bus.fifo_count   = count_q;
    assign bus.uart_tx_busy = (state_q != S_IDLE) || !fifo_empty;
    assign bus.uart_txd     = txd_q;

    // FIFO pointer and occupancy next-state; simultaneous push/pop keeps the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage: data only, no reset needed since occupancy gates every read.
    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.tx_data;
    end

    // Frame sequencer: baud/bit counting, shifting, and the registered line value.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        if (state_q != S_IDLE) baud_d = baud_end ? '0 : baud_q + BW'(1);
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                txd_d  = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = head_par;
                    state_d = S_START;
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DBIT_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PAR;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        txd_d = shift_q[1];
                    end
                end
            end
            S_PAR: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    txd_d   = 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (bit_q == SBIT_LAST) begin
                        bit_d = '0;
                        // Chain straight into the next start bit when work is queued.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = head_par;
                            state_d = S_START;
                            txd_d   = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // State registers; reset aborts any frame and discards queued words.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            txd_q    <= txd_d;
        end
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter: configurable data width, parity mode and stop-bit count.
- Internal transmit FIFO with a valid/ready write interface, so a producer can queue several words and frames are sent back to back with no idle gap.
- Successor to the single-byte, edge-triggered transmitter. Sits between the system fabric (sys_clk domain) and the uart_txd pin.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate; BPS_CNT = CLK_FREQ/UART_BPS (integer divide), which must be >= 2.
- DATA_BITS, 8, data bits per frame, legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame: 1 or 2.
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2 and >= 2.

Ports:
- sys_clk  input  1  system clock, all logic on its rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- tx_valid  input  1  producer has a word on tx_data.
- tx_data  input  DATA_BITS  word to transmit, LSB sent first.
- tx_ready  output  1  FIFO can accept a word (= !full).
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words currently stored in the FIFO.
- uart_tx_busy  output  1  high while the FSM is not in IDLE or the FIFO is non-empty.
- uart_txd  output  1  serial line, idle high, registered output.

Behaviour:
- Reset (sys_rst=1 at a rising edge), effective at that edge:
  - uart_txd=1, tx_ready=1, fifo_count=0, uart_tx_busy=0.
  - FSM goes to IDLE; baud and bit counters clear; FIFO pointers clear.
  - Reset mid-frame aborts the frame: the line returns high at the next edge and queued words are discarded.
- Write handshake:
  - A word is accepted at an edge where tx_valid && tx_ready.
  - tx_data is sampled only at accepting edges; tx_valid while tx_ready=0 has no effect.
  - The producer may hold tx_valid high indefinitely.
- FIFO:
  - First-word-fall-through is not required; the FSM reads the head registered.
  - Push and pop on the same edge are allowed at any count, including count=1, and leave the count unchanged.
  - A push while full cannot occur because tx_ready=0.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: uart_txd=1. At an edge where the FIFO is non-empty, pop the head into the shift register, go to START and drive uart_txd=0 at the same edge.
  - Latency: a word accepted at edge k into an empty FIFO while IDLE drives uart_txd low at edge k+1.
  - START: lasts BPS_CNT cycles, then DATA.
  - DATA: DATA_BITS bits, each BPS_CNT cycles, LSB first, with a shift-register right shift per bit. Then PAR if PARITY!=0, else STOP.
  - PAR: one bit, BPS_CNT cycles, computed over the DATA_BITS data bits. Odd mode makes data ones plus parity bit odd; even mode makes that total even.
  - STOP: uart_txd=1 for STOP_BITS*BPS_CNT cycles. On the final cycle:
    - FIFO non-empty: pop and go directly to START, so the next start bit begins on the very next cycle with zero idle gap.
    - FIFO empty: go to IDLE.
- Frame length is exactly (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BPS_CNT cycles.
- Baud counter: counts 0..BPS_CNT-1 and wraps. It is held at 0 in IDLE and restarts at 0 on every entry to START.
- uart_txd changes only at bit boundaries; no glitches, no extra cycles.
- Illegal parameter values (DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH) are rejected by an elaboration-time check that halts elaboration with an error; no runtime behaviour is defined.

Test Plan:
1. Bench setup: CLK_FREQ=16, UART_BPS=1, so BPS_CNT=16.
2. 8N1, single word 0xA5 written while idle → uart_txd falls one cycle after acceptance. Bits (16 cycles each) are 0,1,0,1,0,0,1,0,1,1, for a 160-cycle frame, then the FSM returns to IDLE and uart_tx_busy drops at the end of the stop bit.
3. PARITY=2 then PARITY=1, word 0xA5 → parity bit 0 (even) and 1 (odd), inserted after bit 7, for a 176-cycle frame. Repeat with 0x01: even parity gives 1, odd gives 0.
4. DATA_BITS=7, STOP_BITS=2, word 0x7F (bits 0..6 of the stimulus word) → 7 data ones, stop high for 32 cycles, 160-cycle frame.
5. FIFO_DEPTH=16, tx_valid held high from idle with 20 distinct words → exactly 17 accepted by edge 16, tx_ready=0 and fifo_count=16. tx_ready rises 1 cycle after each subsequent pop. All 20 frames go out in order, each next start bit immediately after the previous stop bit with zero idle cycles.
6. Assert sys_rst for 1 cycle in the middle of DATA of the second of 3 queued frames → uart_txd=1 at the next edge, fifo_count=0, uart_tx_busy=0, tx_ready=1. A new word 0x3C afterwards is sent as a clean full frame.
